// File: rtl/track_sensor_conditioner_pkg.sv
// Shared constants for the track sensor conditioner and the downstream controller FSM.
// Sensor bit i maps to S(i+1); widths derive from the default cycle counts.
package track_pkg;

  localparam int NUM_SENSORS = 5;

  localparam int S1_IDX = 0;
  localparam int S2_IDX = 1;
  localparam int S3_IDX = 2;
  localparam int S4_IDX = 3;
  localparam int S5_IDX = 4;

  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int STUCK_CYCLES_DEF    = 4096;

  // Counter width for a count that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DB_CNT_W    = cnt_width(DEBOUNCE_CYCLES_DEF);
  localparam int STUCK_CNT_W = $clog2(STUCK_CYCLES_DEF + 1);

  typedef logic [NUM_SENSORS-1:0] sensor_vec_t;

endpackage

// File: rtl/track_sensor_conditioner_if.sv
// Sensor-side bundle: raw inputs and clear in, conditioned levels, strobes and faults out.
interface track_sensor_conditioner_if #(
  parameter int N = track_pkg::NUM_SENSORS
);

  logic [N-1:0] raw_sensor;
  logic         stuck_clr;
  logic [N-1:0] sensor_level;
  logic [N-1:0] sensor_rise;
  logic [N-1:0] sensor_fall;
  logic [N-1:0] sensor_stuck;
  logic         fault_any;

  modport master (
    output raw_sensor,
    output stuck_clr,
    input  sensor_level,
    input  sensor_rise,
    input  sensor_fall,
    input  sensor_stuck,
    input  fault_any
  );

  modport slave (
    input  raw_sensor,
    input  stuck_clr,
    output sensor_level,
    output sensor_rise,
    output sensor_fall,
    output sensor_stuck,
    output fault_any
  );

endinterface

// File: rtl/track_sensor_conditioner_debounce_ch.sv
// One sensor channel: 2-flop synchroniser, stability-count debouncer,
// edge strobes and a saturating stuck-active detector with sticky flag.
module sensor_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = track_pkg::DEBOUNCE_CYCLES_DEF,
  parameter int STUCK_CYCLES    = track_pkg::STUCK_CYCLES_DEF
) (
  input  logic Clock,
  input  logic reset,
  input  logic raw,
  input  logic stuck_clr,
  output logic level,
  output logic rise,
  output logic fall,
  output logic stuck
);
  import track_pkg::*;

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int ST_W = $clog2(STUCK_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STUCK_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_MAX  = ST_W'(STUCK_CYCLES);

  logic            sync1_reg, sync2_reg;
  logic [DB_W-1:0] db_cnt_reg, db_cnt_next;
  logic            level_reg, level_next;
  logic            rise_reg, rise_next;
  logic            fall_reg, fall_next;
  logic [ST_W-1:0] st_cnt_reg, st_cnt_next;
  logic            stuck_reg, stuck_next;

  always_comb begin
    db_cnt_next = db_cnt_reg;
    level_next  = level_reg;
    rise_next   = 1'b0;
    fall_next   = 1'b0;
    // Any sample agreeing with the accepted level restarts the stability count.
    if (sync2_reg == level_reg) begin
      db_cnt_next = '0;
    end else if (db_cnt_reg == DB_LAST) begin
      db_cnt_next = '0;
      level_next  = sync2_reg;
      rise_next   = sync2_reg;
      fall_next   = ~sync2_reg;
    end else begin
      db_cnt_next = db_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    st_cnt_next = st_cnt_reg;
    stuck_next  = stuck_reg;
    // Clear takes priority over a coincident set so the counter restarts cleanly.
    if (stuck_clr) begin
      st_cnt_next = '0;
      stuck_next  = 1'b0;
    end else if (!level_reg) begin
      st_cnt_next = '0;
    end else begin
      if (st_cnt_reg != ST_MAX) st_cnt_next = st_cnt_reg + 1'b1;
      if (st_cnt_reg == ST_LAST) stuck_next = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!reset) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      db_cnt_reg <= '0;
      level_reg  <= 1'b0;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
      st_cnt_reg <= '0;
      stuck_reg  <= 1'b0;
    end else begin
      sync1_reg  <= raw;
      sync2_reg  <= sync1_reg;
      db_cnt_reg <= db_cnt_next;
      level_reg  <= level_next;
      rise_reg   <= rise_next;
      fall_reg   <= fall_next;
      st_cnt_reg <= st_cnt_next;
      stuck_reg  <= stuck_next;
    end
  end

  assign level = level_reg;
  assign rise  = rise_reg;
  assign fall  = fall_reg;
  assign stuck = stuck_reg;

endmodule

// File: rtl/track_sensor_conditioner.sv
// Conditions the raw track sensors for the controller FSM: one debounce channel
// per sensor plus a registered summary fault.
module track_sensor_conditioner #(
  parameter int NUM_SENSORS     = track_pkg::NUM_SENSORS,
  parameter int DEBOUNCE_CYCLES = track_pkg::DEBOUNCE_CYCLES_DEF,
  parameter int STUCK_CYCLES    = track_pkg::STUCK_CYCLES_DEF
) (
  input logic Clock,
  input logic reset,
  track_sensor_conditioner_if.slave bus
);
  import track_pkg::*;

  logic [NUM_SENSORS-1:0] level_vec;
  logic [NUM_SENSORS-1:0] rise_vec;
  logic [NUM_SENSORS-1:0] fall_vec;
  logic [NUM_SENSORS-1:0] stuck_vec;
  logic                   fault_any_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SENSORS; gi++) begin : g_ch
      sensor_debounce_ch #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .STUCK_CYCLES   (STUCK_CYCLES)
      ) u_ch (
        .Clock    (Clock),
        .reset    (reset),
        .raw      (bus.raw_sensor[gi]),
        .stuck_clr(bus.stuck_clr),
        .level    (level_vec[gi]),
        .rise     (rise_vec[gi]),
        .fall     (fall_vec[gi]),
        .stuck    (stuck_vec[gi])
      );
    end
  endgenerate

  always_ff @(posedge Clock) begin
    if (!reset) fault_any_reg <= 1'b0;
    else        fault_any_reg <= |stuck_vec;
  end

  assign bus.sensor_level = level_vec;
  assign bus.sensor_rise  = rise_vec;
  assign bus.sensor_fall  = fall_vec;
  assign bus.sensor_stuck = stuck_vec;
  assign bus.fault_any    = fault_any_reg;

endmodule

// File: tb/tb_track_sensor_conditioner.sv
// Directed bench for track_sensor_conditioner with DEBOUNCE_CYCLES=4, STUCK_CYCLES=32.
module tb_track_sensor_conditioner;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  track_sensor_conditioner_if #(.N(5)) bus ();

  track_sensor_conditioner #(
    .NUM_SENSORS    (5),
    .DEBOUNCE_CYCLES(4),
    .STUCK_CYCLES   (32)
  ) dut (
    .Clock(clk),
    .reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; outputs are then sampled 1 time unit after the last edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"}, {3'b0, bus.sensor_level}, 8'h00);
    chk({tag, "_rise"},  {3'b0, bus.sensor_rise},  8'h00);
    chk({tag, "_fall"},  {3'b0, bus.sensor_fall},  8'h00);
    chk({tag, "_stuck"}, {3'b0, bus.sensor_stuck}, 8'h00);
    chk({tag, "_fault"}, {7'b0, bus.fault_any},    8'h00);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.raw_sensor = 5'b11111;
    bus.stuck_clr  = 1'b0;

    $display("phase reset: hold reset 3 edges with raw=11111");
    step(3);
    chk_all_zero("reset");

    $display("phase release: all channels debounce high");
    rst_n = 1'b1;
    step(5);
    chk("rel_pre_level", {3'b0, bus.sensor_level}, 8'h00);
    step(1);
    chk("rel_level", {3'b0, bus.sensor_level}, 8'h1F);
    chk("rel_rise",  {3'b0, bus.sensor_rise},  8'h1F);
    step(1);
    chk("rel_rise_end", {3'b0, bus.sensor_rise}, 8'h00);

    $display("phase drop: all channels debounce low");
    bus.raw_sensor = 5'b00000;
    step(5);
    chk("drop_pre_level", {3'b0, bus.sensor_level}, 8'h1F);
    chk("drop_pre_fall",  {3'b0, bus.sensor_fall},  8'h00);
    step(1);
    chk("drop_level", {3'b0, bus.sensor_level}, 8'h00);
    chk("drop_fall",  {3'b0, bus.sensor_fall},  8'h1F);
    step(1);
    chk("drop_fall_end", {3'b0, bus.sensor_fall}, 8'h00);

    $display("phase glitch3: raw[0] high 3 cycles is rejected");
    bus.raw_sensor = 5'b00001;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("glitch3_hi", {6'b0, bus.sensor_level[0], bus.sensor_rise[0]}, 8'h00);
    end
    bus.raw_sensor = 5'b00000;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("glitch3_lo", {6'b0, bus.sensor_level[0], bus.sensor_rise[0]}, 8'h00);
    end

    $display("phase pulse5: raw[0] high 5 cycles is accepted");
    bus.raw_sensor = 5'b00001;
    step(5);
    chk("pulse5_pre", {3'b0, bus.sensor_level}, 8'h00);
    bus.raw_sensor = 5'b00000;
    step(1);
    chk("pulse5_level", {3'b0, bus.sensor_level}, 8'h01);
    chk("pulse5_rise",  {3'b0, bus.sensor_rise},  8'h01);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("pulse5_hold", {bus.sensor_level[0], bus.sensor_rise[0], bus.sensor_fall[0], 5'b0}, 8'h80);
    end
    step(1);
    chk("pulse5_fall_level", {3'b0, bus.sensor_level}, 8'h00);
    chk("pulse5_fall",       {3'b0, bus.sensor_fall},  8'h01);
    step(1);
    chk("pulse5_fall_end", {3'b0, bus.sensor_fall}, 8'h00);

    $display("phase chatter: raw[2] 1,1,1,0,1,1,1,1 then held");
    begin
      logic [7:0] pat;
      pat = 8'b1111_0111;
      for (int i = 0; i < 8; i++) begin
        bus.raw_sensor = {2'b00, pat[i], 2'b00};
        step(1);
        chk("chatter_run", {3'b0, bus.sensor_level}, 8'h00);
      end
    end
    step(1);
    chk("chatter_pre", {3'b0, bus.sensor_level}, 8'h00);
    step(1);
    chk("chatter_level", {3'b0, bus.sensor_level}, 8'h04);
    chk("chatter_rise",  {3'b0, bus.sensor_rise},  8'h04);
    bus.raw_sensor = 5'b00000;
    step(6);
    chk("chatter_down", {3'b0, bus.sensor_level}, 8'h00);
    step(1);

    $display("phase indep: raw[1] and raw[3] rise together");
    bus.raw_sensor = 5'b01010;
    step(5);
    chk("indep_pre", {3'b0, bus.sensor_rise}, 8'h00);
    step(1);
    chk("indep_rise",  {3'b0, bus.sensor_rise},  8'h0A);
    chk("indep_level", {3'b0, bus.sensor_level}, 8'h0A);
    step(1);
    chk("indep_rise_end", {3'b0, bus.sensor_rise}, 8'h00);
    bus.raw_sensor = 5'b00000;
    step(6);
    chk("indep_down", {3'b0, bus.sensor_level}, 8'h00);
    step(1);

    $display("phase stuck: raw[4] held high");
    bus.raw_sensor = 5'b10000;
    step(6);
    chk("stuck_level", {3'b0, bus.sensor_level}, 8'h10);
    step(31);
    chk("stuck_pre",       {3'b0, bus.sensor_stuck}, 8'h00);
    chk("stuck_pre_fault", {7'b0, bus.fault_any},    8'h00);
    step(1);
    chk("stuck_set",       {3'b0, bus.sensor_stuck}, 8'h10);
    chk("stuck_set_fault", {7'b0, bus.fault_any},    8'h00);
    step(1);
    chk("stuck_fault", {7'b0, bus.fault_any}, 8'h01);
    bus.raw_sensor = 5'b00000;
    step(10);
    chk("stuck_drop_level", {3'b0, bus.sensor_level}, 8'h00);
    chk("stuck_persist",    {3'b0, bus.sensor_stuck}, 8'h10);
    chk("stuck_persist_fa", {7'b0, bus.fault_any},    8'h01);

    $display("phase clear: pulse stuck_clr");
    bus.stuck_clr = 1'b1;
    step(1);
    bus.stuck_clr = 1'b0;
    chk("clr_stuck",    {3'b0, bus.sensor_stuck}, 8'h00);
    chk("clr_fault_lag", {7'b0, bus.fault_any},   8'h01);
    step(1);
    chk("clr_fault", {7'b0, bus.fault_any}, 8'h00);

    $display("phase midreset: reset during a fall debounce of raw[0]");
    bus.raw_sensor = 5'b00001;
    step(6);
    chk("mid_level", {3'b0, bus.sensor_level}, 8'h01);
    bus.raw_sensor = 5'b00000;
    step(4);
    chk("mid_pre_level", {3'b0, bus.sensor_level}, 8'h01);
    rst_n = 1'b0;
    step(1);
    chk_all_zero("mid_reset");
    rst_n = 1'b1;
    bus.raw_sensor = 5'b00001;
    step(5);
    chk("mid_redeb_pre", {3'b0, bus.sensor_level}, 8'h00);
    step(1);
    chk("mid_redeb_level", {3'b0, bus.sensor_level}, 8'h01);
    chk("mid_redeb_rise",  {3'b0, bus.sensor_rise},  8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/track_sensor_conditioner.md
Name: track_sensor_conditioner

Overview:
- Upstream stage of the train-track controller FSM; conditions the five raw track sensors before the FSM sees them.
- Per channel: 2-flop synchroniser, then a stability-counter debouncer.
- Outputs clean S1..S5 levels plus one-cycle rise/fall strobes.
- Flags sensors stuck active too long, so a blocked or failed sensor cannot freeze the controller silently.

Parameters:
- NUM_SENSORS, 5: number of channels; bit i maps to S(i+1).
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised samples needed to accept a new level; legal range 2..255.
- STUCK_CYCLES, 4096: consecutive cycles of debounced level 1 that raise a stuck fault; must be greater than DEBOUNCE_CYCLES.

Ports:
- Clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on the Clock rising edge).
- raw_sensor  input  NUM_SENSORS  asynchronous raw sensor inputs, active high.
- stuck_clr  input  1  one-cycle pulse; clears all sticky stuck flags.
- sensor_level  output  NUM_SENSORS  debounced levels; drive FSM inputs S1..S5.
- sensor_rise  output  NUM_SENSORS  one-cycle strobe when a debounced level goes 0->1.
- sensor_fall  output  NUM_SENSORS  one-cycle strobe when a debounced level goes 1->0.
- sensor_stuck  output  NUM_SENSORS  sticky per-channel stuck-active fault.
- fault_any  output  1  registered OR of sensor_stuck.

Behaviour:
- Reset (reset=0 at an edge) clears:
  - both synchroniser flops, all debounce counters and all stuck counters to 0;
  - sensor_level, sensor_rise, sensor_fall, sensor_stuck and fault_any to 0.
- Reset wins over every other event. Reset mid-debounce discards partial counts.
- Synchroniser: sync1 <= raw; sync2 <= sync1. Only sync2 is used downstream.
- Debounce counter per channel, width clog2(DEBOUNCE_CYCLES):
  - If sync2 == level: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: level <= sync2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - A single opposite sample restarts the count. Pulses shorter than DEBOUNCE_CYCLES synchronised cycles never reach sensor_level.
- Latency: raw first sampled new at edge k gives sensor_level change at edge k+DEBOUNCE_CYCLES+1, if raw holds steady through that edge.
- Strobes:
  - sensor_rise[i] and sensor_fall[i] are registered and rise in the same cycle the level changes; each lasts exactly one cycle.
  - Rise and fall never coincide on one channel.
  - Different channels are independent and may strobe together.
- Stuck detection, per channel:
  - Counter increments while level==1 and saturates at STUCK_CYCLES.
  - Counter clears to 0 when level==0.
  - When the counter reaches STUCK_CYCLES-1 while level==1, sensor_stuck[i] <= 1 on the next edge.
  - Flag stays set after the level drops, until stuck_clr or reset.
- stuck_clr:
  - Clears all flags and all stuck counters.
  - Simultaneous with a set condition: clear wins this cycle; the counter restarts from 0.
- fault_any is one cycle behind sensor_stuck.
- sensor_level has no combinational path from raw_sensor; all outputs are registered.

Decomposition:
- Shared package track_pkg holds:
  - NUM_SENSORS;
  - sensor index constants S1_IDX..S5_IDX = 0..4;
  - DEBOUNCE_CYCLES and STUCK_CYCLES defaults;
  - width constants derived by clog2.
- The controller FSM takes the same package for its sensor indexing.
- One sub-module: sensor_debounce_ch. It holds a single channel's synchroniser, debounce counter, stuck counter and strobes.
- The top instantiates NUM_SENSORS copies via generate, plus the fault_any OR register.

Test Plan (DEBOUNCE_CYCLES=4, STUCK_CYCLES=32):
- Reset check: reset=0 for 3 edges, raw_sensor=5'b11111 → all outputs 0. Release reset; raw held → sensor_level=5'b11111 at edge k+5, sensor_rise=5'b11111 for exactly one cycle.
- Glitch rejection: raw[0] high for 3 cycles then low → sensor_level[0] and sensor_rise[0] stay 0 throughout. Repeat with 5 cycles high → level[0] rises at edge k+5 and falls 5 edges after raw returns low; exactly one rise and one fall strobe.
- Chatter restart: raw[2] pattern 1,1,1,0,1,1,1,1 → level[2] rises only 5 edges after the final 1-run begins. A single 0 sample resets the count.
- Independent channels: raw[1] and raw[3] rise on the same edge → sensor_rise=5'b01010 in one cycle. Other bits stay 0.
- Stuck fault: hold raw[4]=1 → sensor_stuck[4]=1 exactly 32 cycles after level[4] rose; fault_any=1 one cycle later. Drop raw → flag persists. Pulse stuck_clr → sensor_stuck=0, then fault_any=0 next cycle.
- Reset mid-operation: assert reset=0 two cycles into a debounce window with level[0]=1 → all outputs 0 next edge. After release, stable raw re-debounces from count 0 with full latency.
